// File: rtl/lcd_controller_ng_if.sv
// lcd_controller_ng_if: CPU bus and pixel scanout signals of the LCD controller.
//   bus_write/bus_read : CPU strobes (level, acted on at rising edge)
//   address_in/data_in : CPU address and write data
//   data_out           : registered read data
//   frame_start        : scanout start pulse
//   pix_valid/pix_ready: pixel stream handshake
//   pix_data/x/y       : pixel value and coordinates
//   frame_done         : end-of-frame pulse
// master = CPU/video side, slave = controller.
interface lcd_controller_ng_if #(
  parameter int unsigned VIS_ROWS = 64
);
  logic                        bus_write;
  logic                        bus_read;
  logic [23:0]                 address_in;
  logic [7:0]                  data_in;
  logic [7:0]                  data_out;
  logic                        frame_start;
  logic                        pix_valid;
  logic                        pix_ready;
  logic                        pix_data;
  logic [7:0]                  pix_x;
  logic [$clog2(VIS_ROWS)-1:0] pix_y;
  logic                        frame_done;

  modport master (
    output bus_write, bus_read, address_in, data_in, frame_start, pix_ready,
    input  data_out, pix_valid, pix_data, pix_x, pix_y, frame_done
  );

  modport slave (
    input  bus_write, bus_read, address_in, data_in, frame_start, pix_ready,
    output data_out, pix_valid, pix_data, pix_x, pix_y, frame_done
  );
endinterface

// File: rtl/lcd_controller_ng.sv
// lcd_controller_ng: Pokemon Mini LCD controller with display RAM, command decode,
// read-modify-write column restore, registered bus read and a pixel scanout engine.
//   clk, reset_n : clock, asynchronous active-low reset
//   lcd          : bus + scanout interface (slave modport)
//   contrast     : current contrast value
//   display_on   : display enable
module lcd_controller_ng #(
  parameter int unsigned COLUMNS     = 132,
  parameter int unsigned PAGES       = 9,
  parameter int unsigned VIS_COLUMNS = 96,
  parameter int unsigned VIS_ROWS    = 64,
  parameter logic [23:0] CMD_ADDR    = 24'h20FE
) (
  input  logic                clk,
  input  logic                reset_n,
  lcd_controller_ng_if.slave  lcd,
  output logic [5:0]          contrast,
  output logic                display_on
);
  localparam int unsigned Depth    = COLUMNS * PAGES;
  localparam int unsigned AW       = $clog2(Depth);
  localparam int unsigned YW       = $clog2(VIS_ROWS);
  localparam logic [23:0] DatAddr  = CMD_ADDR + 24'd1;
  localparam logic [7:0]  ColMax   = 8'(COLUMNS - 1);
  localparam logic [3:0]  LastPage = 4'(PAGES - 1);
  localparam logic [7:0]  XLast    = 8'(VIS_COLUMNS - 1);
  localparam logic [YW-1:0] YLast  = YW'(VIS_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} scan_state_e;

  logic [7:0] mem [Depth];

  logic       write_latch_q, read_latch_q;
  logic [7:0] column_q, column_d, rmw_column_q, rmw_column_d;
  logic [3:0] page_q, page_d;
  logic [5:0] start_line_q, start_line_d, contrast_q, contrast_d;
  logic       pending_q, pending_d, seg_dir_q, seg_dir_d, max_contrast_q, max_contrast_d;
  logic       all_on_q, all_on_d, invert_q, invert_d, display_on_q, display_on_d;
  logic       row_order_q, row_order_d, rmw_q, rmw_d;
  logic [7:0] data_out_q, data_out_d;

  scan_state_e   state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_q, pix_d;

  logic          is_cmd, is_dat, wr_edge, rd_edge, addr_ok, last_page, ram_we;
  logic [7:0]    col_eff, col_inc, wdata, rmask;
  logic [AW-1:0] bus_addr, scan_addr;
  logic [YW-1:0] row_sel, src_row;

  // Max-contrast flag is stored for software but drives nothing here.
  logic unused_max_contrast;
  assign unused_max_contrast = max_contrast_q;

  always_comb begin
    is_cmd    = lcd.address_in == CMD_ADDR;
    is_dat    = lcd.address_in == DatAddr;
    wr_edge   = lcd.bus_write & ~write_latch_q;
    rd_edge   = lcd.bus_read & ~read_latch_q & ~wr_edge;
    addr_ok   = (32'(page_q) < PAGES) && (32'(column_q) < COLUMNS);
    last_page = page_q == LastPage;
    col_eff   = seg_dir_q ? ColMax - column_q : column_q;
    col_inc   = (column_q < ColMax) ? column_q + 8'd1 : column_q;
    bus_addr  = AW'(32'(page_q) * COLUMNS + 32'(col_eff));
    rmask     = last_page ? 8'h01 : 8'hFF;
    wdata     = lcd.data_in & rmask;
    ram_we    = wr_edge & is_dat & ~pending_q & addr_ok;
  end

  // Control registers: command decode, data-port column stepping, contrast capture.
  always_comb begin
    column_d     = column_q;
    rmw_column_d = rmw_column_q;
    page_d       = page_q;
    start_line_d = start_line_q;
    contrast_d   = contrast_q;
    pending_d    = pending_q;
    seg_dir_d    = seg_dir_q;
    max_contrast_d = max_contrast_q;
    all_on_d     = all_on_q;
    invert_d     = invert_q;
    display_on_d = display_on_q;
    row_order_d  = row_order_q;
    rmw_d        = rmw_q;
    if (wr_edge && (is_cmd || is_dat) && pending_q) begin
      // A pending contrast set swallows the next write on either port.
      contrast_d = lcd.data_in[5:0];
      pending_d  = 1'b0;
    end else if (wr_edge && is_dat) begin
      column_d = col_inc;
    end else if (wr_edge && is_cmd) begin
      if (lcd.data_in[7:6] == 2'b01) begin
        start_line_d = lcd.data_in[5:0];
      end else begin
        case (lcd.data_in[7:4])
          4'h0: if (!rmw_q) column_d[3:0] = lcd.data_in[3:0];
          4'h1: if (!rmw_q) column_d[7:4] = lcd.data_in[3:0];
          4'h8: if (lcd.data_in[3:0] == 4'h1) pending_d = 1'b1;
          4'hA: begin
            case (lcd.data_in[3:1])
              3'b000:  seg_dir_d      = lcd.data_in[0];
              3'b001:  max_contrast_d = lcd.data_in[0];
              3'b010:  all_on_d       = lcd.data_in[0];
              3'b011:  invert_d       = lcd.data_in[0];
              3'b111:  display_on_d   = lcd.data_in[0];
              default: ;
            endcase
          end
          4'hB: page_d      = lcd.data_in[3:0];
          4'hC: row_order_d = lcd.data_in[3];
          4'hE: begin
            case (lcd.data_in[3:0])
              4'h0: begin
                rmw_d        = 1'b1;
                rmw_column_d = column_q;
              end
              4'hE: begin
                rmw_d    = 1'b0;
                column_d = rmw_column_q;
              end
              4'h2: begin
                column_d       = '0;
                rmw_column_d   = '0;
                page_d         = '0;
                start_line_d   = '0;
                contrast_d     = 6'h20;
                pending_d      = 1'b0;
                seg_dir_d      = 1'b0;
                max_contrast_d = 1'b0;
                all_on_d       = 1'b0;
                invert_d       = 1'b0;
                display_on_d   = 1'b0;
                row_order_d    = 1'b0;
                rmw_d          = 1'b0;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end else if (rd_edge && is_cmd && pending_q) begin
      contrast_d = 6'h3F;
      pending_d  = 1'b0;
    end else if (rd_edge && is_dat && !rmw_q) begin
      column_d = col_inc;
    end
  end

  always_comb begin
    data_out_d = 8'h00;
    if (pending_q) begin
      data_out_d = 8'h00;
    end else if (is_cmd) begin
      data_out_d = {2'b01, display_on_q, 5'b0};
    end else if (is_dat && addr_ok) begin
      data_out_d = mem[bus_addr] & rmask;
    end
  end

  // Scanout source: optional row flip, then start-line rotation within the visible rows.
  always_comb begin
    row_sel   = row_order_q ? ~y_q : y_q;
    src_row   = YW'(32'(row_sel) + 32'(start_line_q));
    scan_addr = AW'(32'(src_row >> 3) * COLUMNS + 32'(x_q));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    unique case (state_q)
      StIdle: begin
        if (lcd.frame_start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Controls are sampled here so a stalled pixel never changes.
        if (!display_on_q)  pix_d = 1'b0;
        else if (all_on_q)  pix_d = 1'b1;
        else                pix_d = mem[scan_addr][src_row[2:0]] ^ invert_q;
        state_d = StPresent;
      end
      StPresent: begin
        if (lcd.pix_ready) begin
          if (x_q == XLast) begin
            x_d     = '0;
            y_d     = y_q + YW'(1);
            state_d = (y_q == YLast) ? StDone : StFetch;
          end else begin
            x_d     = x_q + 8'd1;
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[bus_addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_latch_q  <= 1'b0;
      read_latch_q   <= 1'b0;
      column_q       <= '0;
      rmw_column_q   <= '0;
      page_q         <= '0;
      start_line_q   <= '0;
      contrast_q     <= 6'h20;
      pending_q      <= 1'b0;
      seg_dir_q      <= 1'b0;
      max_contrast_q <= 1'b0;
      all_on_q       <= 1'b0;
      invert_q       <= 1'b0;
      display_on_q   <= 1'b0;
      row_order_q    <= 1'b0;
      rmw_q          <= 1'b0;
      data_out_q     <= '0;
      state_q        <= StIdle;
      x_q            <= '0;
      y_q            <= '0;
      pix_q          <= 1'b0;
    end else begin
      write_latch_q  <= lcd.bus_write;
      read_latch_q   <= lcd.bus_read;
      column_q       <= column_d;
      rmw_column_q   <= rmw_column_d;
      page_q         <= page_d;
      start_line_q   <= start_line_d;
      contrast_q     <= contrast_d;
      pending_q      <= pending_d;
      seg_dir_q      <= seg_dir_d;
      max_contrast_q <= max_contrast_d;
      all_on_q       <= all_on_d;
      invert_q       <= invert_d;
      display_on_q   <= display_on_d;
      row_order_q    <= row_order_d;
      rmw_q          <= rmw_d;
      data_out_q     <= data_out_d;
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pix_q          <= pix_d;
    end
  end

  assign lcd.data_out   = data_out_q;
  assign lcd.pix_valid  = state_q == StPresent;
  assign lcd.frame_done = state_q == StDone;
  assign lcd.pix_data   = pix_q;
  assign lcd.pix_x      = x_q;
  assign lcd.pix_y      = y_q;
  assign contrast       = contrast_q;
  assign display_on     = display_on_q;
endmodule
